// File: rtl/axi4_lite_regbank_if.sv
// rtl/axi4_lite_regbank_if.sv - native-side request/response bundle between the AXI4-Lite slave and the register bank
interface axi4_lite_regbank_if;
    logic [31:0] ctrl_addr;
    logic [31:0] ctrl_wdata;
    logic [3:0]  ctrl_wstrb;
    logic        ctrl_write_req;
    logic        ctrl_read_req;
    logic [31:0] ctrl_rdata;
    logic        ctrl_write_done;
    logic        ctrl_read_done;
    logic [1:0]  ctrl_resp;
    logic        irq;

    modport slave (
        input  ctrl_addr, ctrl_wdata, ctrl_wstrb, ctrl_write_req, ctrl_read_req,
        output ctrl_rdata, ctrl_write_done, ctrl_read_done, ctrl_resp, irq
    );

    modport master (
        output ctrl_addr, ctrl_wdata, ctrl_wstrb, ctrl_write_req, ctrl_read_req,
        input  ctrl_rdata, ctrl_write_done, ctrl_read_done, ctrl_resp, irq
    );
endinterface

// File: rtl/axi4_lite_regbank.sv
// rtl/axi4_lite_regbank.sv - ID/CTRL/STATUS/COUNTER/scratch register bank behind the AXI4-Lite slave native port
module axi4_lite_regbank #(
    parameter int          NUM_REGS    = 4,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA41E_0001
) (
    input  logic                   clk,
    input  logic                   rst_n,
    axi4_lite_regbank_if.slave     bus
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);

    logic [0:0]  r_state;
    logic [7:0]  r_wait_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_is_write;
    logic        r_rd_pending;
    logic [1:0]  r_ctrl;
    logic [2:0]  r_status;
    logic [31:0] r_counter;
    logic [31:0] r_scratch [NUM_REGS];
    logic [31:0] r_rdata;
    logic [1:0]  r_resp;
    logic        r_wdone;
    logic        r_rdone;
    logic        r_irq;

    logic [7:0]  w_off;
    logic [7:0]  w_scr_off;
    logic [5:0]  w_idx;
    logic        w_sel_id, w_sel_ctrl, w_sel_status, w_sel_cnt, w_sel_scr;
    logic        w_err;
    logic [31:0] w_bmask;
    logic [31:0] w_rd_val;
    logic        w_commit;
    logic        w_wr_ok;
    logic        w_drop;
    logic        w_wrap;
    logic [2:0]  w_status_clr;
    logic [2:0]  w_status_set;
    logic        w_unused;

    // Only the low address byte decodes; upper bits alias onto the same map.
    assign w_unused = ^r_addr[31:8];

    assign w_commit = (r_state == S_WAIT) && (r_wait_cnt == 8'd0);
    assign w_wr_ok  = w_commit && r_is_write && !w_err;
    assign w_drop   = (r_state != S_IDLE) && (bus.ctrl_write_req || bus.ctrl_read_req);
    assign w_wrap   = r_ctrl[0] && (r_counter == 32'hFFFF_FFFF);
    assign w_bmask  = {{8{r_wstrb[3]}}, {8{r_wstrb[2]}}, {8{r_wstrb[1]}}, {8{r_wstrb[0]}}};

    always_comb begin
        w_off        = r_addr[7:0];
        w_scr_off    = w_off - 8'h10;
        w_idx        = w_scr_off[7:2];
        w_sel_id     = (w_off == 8'h00);
        w_sel_ctrl   = (w_off == 8'h04);
        w_sel_status = (w_off == 8'h08);
        w_sel_cnt    = (w_off == 8'h0C);
        w_sel_scr    = (w_off >= 8'h10) && (w_idx < 6'(NUM_REGS));
        w_err        = (w_off[1:0] != 2'b00)
                     || !(w_sel_id || w_sel_ctrl || w_sel_status || w_sel_cnt || w_sel_scr)
                     || (r_is_write && (w_sel_id || w_sel_cnt));
    end

    always_comb begin
        w_rd_val = 32'd0;
        if (w_sel_id)     w_rd_val = ID_VALUE;
        if (w_sel_ctrl)   w_rd_val = {30'd0, r_ctrl};
        if (w_sel_status) w_rd_val = {29'd0, r_status};
        if (w_sel_cnt)    w_rd_val = r_counter;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_sel_scr && (w_idx == 6'(i))) w_rd_val = r_scratch[i];
        end
    end

    // Set sources are ORed in after the clear so a same-cycle set survives a W1C.
    always_comb begin
        w_status_clr = 3'd0;
        if (w_wr_ok && w_sel_status) w_status_clr = r_wdata[2:0] & w_bmask[2:0];
        w_status_set = {w_drop, w_commit && w_err, w_wrap};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= 8'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_wstrb      <= 4'd0;
            r_is_write   <= 1'b0;
            r_rd_pending <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.ctrl_write_req || bus.ctrl_read_req) begin
                        r_addr       <= bus.ctrl_addr;
                        r_wdata      <= bus.ctrl_wdata;
                        r_wstrb      <= bus.ctrl_wstrb;
                        r_is_write   <= bus.ctrl_write_req;
                        r_rd_pending <= bus.ctrl_write_req && bus.ctrl_read_req;
                        r_wait_cnt   <= WAIT_INIT;
                        r_state      <= S_WAIT;
                    end
                end
                default: begin
                    if (r_wait_cnt != 8'd0) begin
                        r_wait_cnt <= r_wait_cnt - 8'd1;
                    end else if (r_rd_pending) begin
                        // Write done; the read captured alongside it reuses the same address.
                        r_rd_pending <= 1'b0;
                        r_is_write   <= 1'b0;
                        r_wait_cnt   <= WAIT_INIT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdone <= 1'b0;
            r_rdone <= 1'b0;
            r_resp  <= 2'b00;
            r_rdata <= 32'd0;
        end else begin
            r_wdone <= w_commit && r_is_write;
            r_rdone <= w_commit && !r_is_write;
            if (w_commit) r_resp <= w_err ? 2'b10 : 2'b00;
            if (w_commit && !r_is_write) r_rdata <= w_err ? 32'd0 : w_rd_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl    <= 2'd0;
            r_status  <= 3'd0;
            r_counter <= 32'd0;
            r_irq     <= 1'b0;
        end else begin
            if (w_wr_ok && w_sel_ctrl) r_ctrl <= (r_ctrl & ~w_bmask[1:0]) | (r_wdata[1:0] & w_bmask[1:0]);
            r_status <= (r_status & ~w_status_clr) | w_status_set;
            if (r_ctrl[0]) r_counter <= r_counter + 32'd1;
            r_irq <= r_status[0] && r_ctrl[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_scratch[i] <= 32'd0;
        end else if (w_wr_ok && w_sel_scr) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_idx == 6'(i)) r_scratch[i] <= (r_scratch[i] & ~w_bmask) | (r_wdata & w_bmask);
            end
        end
    end

    assign bus.ctrl_rdata      = r_rdata;
    assign bus.ctrl_write_done = r_wdone;
    assign bus.ctrl_read_done  = r_rdone;
    assign bus.ctrl_resp       = r_resp;
    assign bus.irq             = r_irq;

endmodule

// File: tb/tb_axi4_lite_regbank.sv
// tb/tb_axi4_lite_regbank.sv - directed checks of the register bank with zero and three wait states
module tb_axi4_lite_regbank;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    logic [31:0] t_addr  [2];
    logic [31:0] t_wdata [2];
    logic [3:0]  t_wstrb [2];
    logic        t_wreq  [2];
    logic        t_rreq  [2];
    logic [31:0] o_rdata [2];
    logic        o_wdone [2];
    logic        o_rdone [2];
    logic [1:0]  o_resp  [2];
    logic        o_irq   [2];

    axi4_lite_regbank_if if0();
    axi4_lite_regbank_if if3();

    assign if0.ctrl_addr      = t_addr[0];
    assign if0.ctrl_wdata     = t_wdata[0];
    assign if0.ctrl_wstrb     = t_wstrb[0];
    assign if0.ctrl_write_req = t_wreq[0];
    assign if0.ctrl_read_req  = t_rreq[0];
    assign if3.ctrl_addr      = t_addr[1];
    assign if3.ctrl_wdata     = t_wdata[1];
    assign if3.ctrl_wstrb     = t_wstrb[1];
    assign if3.ctrl_write_req = t_wreq[1];
    assign if3.ctrl_read_req  = t_rreq[1];
    assign o_rdata[0] = if0.ctrl_rdata;
    assign o_wdone[0] = if0.ctrl_write_done;
    assign o_rdone[0] = if0.ctrl_read_done;
    assign o_resp[0]  = if0.ctrl_resp;
    assign o_irq[0]   = if0.irq;
    assign o_rdata[1] = if3.ctrl_rdata;
    assign o_wdone[1] = if3.ctrl_write_done;
    assign o_rdone[1] = if3.ctrl_read_done;
    assign o_resp[1]  = if3.ctrl_resp;
    assign o_irq[1]   = if3.irq;

    axi4_lite_regbank #(.NUM_REGS(4), .WAIT_CYCLES(0), .ID_VALUE(32'hA41E_0001)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    axi4_lite_regbank #(.NUM_REGS(4), .WAIT_CYCLES(3), .ID_VALUE(32'hA41E_0001)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input int s, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] st, output logic [1:0] resp, output int lat);
        t_addr[s] = a; t_wdata[s] = d; t_wstrb[s] = st; t_wreq[s] = 1'b1;
        @(negedge clk);
        t_wreq[s] = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (o_wdone[s]) begin lat = k; break; end
        end
        resp = o_resp[s];
    endtask

    task automatic do_read(input int s, input logic [31:0] a, output logic [31:0] data,
                           output logic [1:0] resp, output int lat);
        t_addr[s] = a; t_rreq[s] = 1'b1;
        @(negedge clk);
        t_rreq[s] = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (o_rdone[s]) begin lat = k; break; end
        end
        data = o_rdata[s];
        resp = o_resp[s];
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        int          lat;
        int          wk, rk, nw, nr, nd;
        logic [31:0] rdv;

        n_checks = 0;
        n_errors = 0;
        for (int s = 0; s < 2; s++) begin
            t_addr[s] = 32'd0; t_wdata[s] = 32'd0; t_wstrb[s] = 4'd0;
            t_wreq[s] = 1'b0;  t_rreq[s] = 1'b0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs_w0", {o_rdata[0], 2'(o_resp[0]), 1'(o_wdone[0]), 1'(o_rdone[0]), 1'(o_irq[0])}, 32'd0);
        check("reset_outputs_w3", {o_rdata[1], 2'(o_resp[1]), 1'(o_wdone[1]), 1'(o_rdone[1]), 1'(o_irq[1])}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_read(0, 32'h0000_0000, rd, rs, lat);
        check("id_latency", 32'(lat), 32'd1);
        check("id_rdata", rd, 32'hA41E_0001);
        check("id_resp", 32'(rs), 32'd0);

        do_write(0, 32'h0000_0010, 32'hDEAD_BEEF, 4'b0101, rs, lat);
        check("scr_wr_latency", 32'(lat), 32'd1);
        check("scr_wr_resp", 32'(rs), 32'd0);
        do_read(0, 32'h0000_0010, rd, rs, lat);
        check("scr_strobed_rdata", rd, 32'h00AD_00EF);
        check("scr_rd_resp", 32'(rs), 32'd0);

        do_write(0, 32'h0000_0000, 32'h1234_5678, 4'hF, rs, lat);
        check("id_wr_slverr", 32'(rs), 32'd2);
        do_read(0, 32'hFFFF_FF08, rd, rs, lat);
        check("status_after_err_alias", rd, 32'h0000_0002);

        do_read(0, 32'h0000_0050, rd, rs, lat);
        check("beyond_scr_resp", 32'(rs), 32'd2);
        check("beyond_scr_rdata", rd, 32'd0);
        do_read(0, 32'h0000_0012, rd, rs, lat);
        check("misaligned_resp", 32'(rs), 32'd2);
        check("misaligned_rdata", rd, 32'd0);

        do_write(0, 32'h0000_0008, 32'h0000_0002, 4'hF, rs, lat);
        check("status_w1c_resp", 32'(rs), 32'd0);
        do_read(0, 32'h0000_0008, rd, rs, lat);
        check("status_cleared", rd, 32'd0);

        force dut0.r_counter = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut0.r_counter;
        do_write(0, 32'h0000_0004, 32'h0000_0003, 4'hF, rs, lat);
        check("ctrl_wr_resp", 32'(rs), 32'd0);
        repeat (2) @(negedge clk);
        check("irq_before_wrap_delay", 32'(o_irq[0]), 32'd0);
        @(negedge clk);
        check("irq_after_wrap", 32'(o_irq[0]), 32'd1);
        do_read(0, 32'h0000_0008, rd, rs, lat);
        check("status_wrap_bit", rd, 32'h0000_0001);
        do_write(0, 32'h0000_0008, 32'h0000_0001, 4'hF, rs, lat);
        @(negedge clk);
        check("irq_dropped", 32'(o_irq[0]), 32'd0);

        t_addr[1] = 32'h0000_0014; t_wdata[1] = 32'h1234_5678; t_wstrb[1] = 4'hF;
        t_wreq[1] = 1'b1; t_rreq[1] = 1'b1;
        @(negedge clk);
        t_wreq[1] = 1'b0; t_rreq[1] = 1'b0;
        wk = -1; rk = -1; nw = 0; nr = 0; rdv = 32'd0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) t_rreq[1] = 1'b1;
            if (k == 2) t_rreq[1] = 1'b0;
            if (o_wdone[1]) begin nw++; if (wk < 0) wk = k; end
            if (o_rdone[1]) begin nr++; if (rk < 0) begin rk = k; rdv = o_rdata[1]; end end
        end
        check("simul_write_done_at", 32'(wk), 32'd4);
        check("simul_read_done_at", 32'(rk), 32'd8);
        check("simul_done_counts", {16'(nw), 16'(nr)}, {16'd1, 16'd1});
        check("simul_read_data", rdv, 32'h1234_5678);
        do_read(1, 32'h0000_0008, rd, rs, lat);
        check("w3_read_latency", 32'(lat), 32'd4);
        check("overrun_status", rd, 32'h0000_0004);

        do_write(1, 32'h0000_0004, 32'h0000_0002, 4'hF, rs, lat);
        do_read(1, 32'h0000_0004, rd, rs, lat);
        check("w3_ctrl_readback", rd, 32'h0000_0002);
        t_addr[1] = 32'h0000_0004; t_wdata[1] = 32'h0000_0001; t_wstrb[1] = 4'hF; t_wreq[1] = 1'b1;
        @(negedge clk);
        t_wreq[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midwait_reset_outputs", {o_rdata[1], 2'(o_resp[1]), 1'(o_wdone[1]), 1'(o_rdone[1]), 1'(o_irq[1])}, 32'd0);
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 4) rst_n = 1'b1;
            if (o_wdone[1] || o_rdone[1]) nd++;
        end
        check("aborted_no_done", 32'(nd), 32'd0);
        do_read(1, 32'h0000_0004, rd, rs, lat);
        check("ctrl_after_reset", rd, 32'd0);
        check("ctrl_after_reset_resp", 32'(rs), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi4_lite_regbank.md
Name: axi4_lite_regbank

Overview:
- Register bank that sits directly downstream of the AXI4-Lite slave and consumes its native-side ctrl_* request interface.
- Holds an ID register, a control register, a W1C status register, a free-running cycle counter and NUM_REGS byte-strobed scratch registers.
- Returns rdata, a response code and single-cycle done pulses to the slave.
- Provides a programmable wait-state delay so the bench can stretch slave response latency.

Parameters:
NUM_REGS, 4, number of scratch registers (1..16)
WAIT_CYCLES, 0, extra cycles between request capture and done pulse (0..255)
ID_VALUE, 32'hA41E_0001, constant returned by the ID register

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
ctrl_addr  input  32  byte address, valid in the request cycle
ctrl_wdata  input  32  write data, valid with ctrl_write_req
ctrl_wstrb  input  4  byte strobes, valid with ctrl_write_req
ctrl_write_req  input  1  single-cycle write request pulse
ctrl_read_req  input  1  single-cycle read request pulse
ctrl_rdata  output  32  read data, valid in the ctrl_read_done cycle, held until the next read_done
ctrl_write_done  output  1  single-cycle write completion pulse
ctrl_read_done  output  1  single-cycle read completion pulse
ctrl_resp  output  2  2'b00 OKAY, 2'b10 SLVERR; valid with either done pulse, held after it
irq  output  1  registered interrupt, equals STATUS[0] & CTRL[1]

Behaviour:
- Reset values (async): all outputs 0; CTRL=0; STATUS=0; COUNTER=0; scratch=0; FSM in IDLE; pending-read flag cleared. A reset mid-transaction aborts the transaction with no done pulse.
- Decode uses ctrl_addr[7:0] only; upper bits alias.
- Register map:
  - 0x00 ID: read-only, returns ID_VALUE.
  - 0x04 CTRL: bits[1:0] read/write (bit0 = counter enable, bit1 = irq enable); other bits read 0.
  - 0x08 STATUS: W1C. bit0 = counter wrapped; bit1 = error access seen; bit2 = request overrun.
  - 0x0C COUNTER: read-only.
  - 0x10 + 4*i, i < NUM_REGS: SCRATCH[i], read/write.
- SLVERR conditions (write has no effect; read returns 0):
  - ctrl_addr[1:0] != 0
  - address beyond the last scratch register
  - write to ID or COUNTER
  - Any SLVERR also sets STATUS[1].
- Write strobes: SCRATCH and CTRL update only the strobed byte lanes. STATUS clears only the bits written as 1 within strobed lanes.
- FSM:
  - IDLE: a request captures addr, wdata, wstrb and type, then moves to WAIT. Done pulses and updates are handled in WAIT (see Latency).
  - WAIT: a wait counter loads WAIT_CYCLES and decrements. At 0, the write commits or the read samples, and the done pulse with ctrl_resp is registered for the next cycle. Returns to IDLE, or re-enters WAIT when a read is pending.
- Latency: request at cycle N gives done at cycle N+1+WAIT_CYCLES. A written value is visible to reads from the cycle after done.
- Simultaneous write_req and read_req in IDLE: the write is serviced first. The read is latched as pending and its done follows at (write done)+1+WAIT_CYCLES.
- A request arriving while not in IDLE is dropped, with no done pulse, and sets STATUS[2].
- COUNTER increments every cycle while CTRL[0]=1. It wraps from 32'hFFFF_FFFF to 0 and sets STATUS[0] on the wrap cycle.
- If a STATUS bit is set and W1C-cleared in the same cycle, the set wins.
- irq is registered from STATUS and CTRL: it follows them with 1-cycle delay.

Test Plan:
- Reset, then read 0x00 -> read_done at N+1 (WAIT_CYCLES=0), rdata=32'hA41E_0001, resp=00; all outputs 0 during reset.
- Write 0x10 = 32'hDEADBEEF with wstrb=4'b0101, then read 0x10 -> rdata=32'h00AD00EF, resp=00. Write to 0x00 -> write_done with resp=10, STATUS=32'h2.
- Read 0x50 with NUM_REGS=4, and read 0x12 -> each gives resp=10, rdata=0. Write 0x08 = 32'h2 -> STATUS clears to 0.
- Preload COUNTER near wrap via a bench force to 32'hFFFF_FFFE, then write CTRL=32'h3 -> counter wraps, STATUS[0]=1, irq high one cycle later. Write 0x08 = 1 -> irq drops.
- WAIT_CYCLES=3, write_req and read_req in the same cycle N -> write_done at N+4, read_done at N+8. A read_req at N+2 is dropped and sets STATUS[2].
- Assert rst_n low during WAIT -> no done pulse, outputs 0 immediately. After release, the next read of 0x04 returns 0.
